// File: rtl/fifo_pkg.sv
// Shared pointer type and occupancy helper for the RAM-backed FIFO controller.
package fifo_pkg;
  localparam int ADDR_W = 3;

  typedef logic [ADDR_W:0] ptr_t;

  // Wrap-bit pointers: modular subtraction yields occupancy 0..depth directly.
  function automatic ptr_t ptr_count(input ptr_t wr, input ptr_t rd);
    return ptr_t'(wr - rd);
  endfunction
endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrap-bit FIFO pointer: increments on inc, cleared by asynchronous reset.
module ram_fifo_ptr
  import fifo_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output ptr_t ptr
);

  ptr_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_t'(ptr_q + 1'b1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO pointer/flag controller sequencing a 1W/1R dual-port RAM; data never passes through.
module ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int addr_width = ADDR_W,
  parameter int af_level   = 6,
  parameter int ae_level   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  clr_err,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_w_addr,
  output logic [addr_width-1:0] ram_r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam ptr_t AF_LVL = ptr_t'(af_level);
  localparam ptr_t AE_LVL = ptr_t'(ae_level);

  ptr_t wr_ptr, rd_ptr, cnt;
  logic push_ok, pop_ok;
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  ram_fifo_ptr u_wr_ptr (.clk(clk), .reset(reset), .inc(push_ok), .ptr(wr_ptr));
  ram_fifo_ptr u_rd_ptr (.clk(clk), .reset(reset), .inc(pop_ok),  .ptr(rd_ptr));

  assign cnt   = ptr_count(wr_ptr, rd_ptr);
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[addr_width-1:0] == rd_ptr[addr_width-1:0]) &&
                 (wr_ptr[addr_width] != rd_ptr[addr_width]);

  assign almost_full  = (cnt >= AF_LVL);
  assign almost_empty = (cnt <= AE_LVL);
  assign count        = cnt;

  assign push_ok    = wr_req && !full;
  assign pop_ok     = rd_req && !empty;
  assign ram_we     = push_ok;
  assign ram_w_addr = wr_ptr[addr_width-1:0];
  assign ram_r_addr = rd_ptr[addr_width-1:0];

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_req && full)  overflow_d  = 1'b1;
    if (rd_req && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: local RAM array plus a queue-based reference FIFO.
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_req = 1'b0, rd_req = 1'b0, clr_err = 1'b0;
  logic       ram_we;
  logic [2:0] ram_w_addr, ram_r_addr;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;
  logic [7:0] w_data = 8'h00;
  logic [7:0] r_data;
  logic [7:0] mem [0:DEPTH-1];

  int nchecks = 0;
  int nerrors = 0;

  logic [7:0] q[$];
  int  wcnt = 0, rcnt = 0;
  bit  m_ov = 0, m_un = 0;

  ram_fifo_ctrl #(.addr_width(3), .af_level(AF), .ae_level(AE)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req), .clr_err(clr_err),
    .ram_we(ram_we), .ram_w_addr(ram_w_addr), .ram_r_addr(ram_r_addr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_w_addr] <= w_data;
  assign r_data = mem[ram_r_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_flags();
    int n = q.size();
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == DEPTH);
    chk("almost_full", almost_full, n >= AF);
    chk("almost_empty", almost_empty, n <= AE);
    chk("overflow", overflow, m_ov);
    chk("underflow", underflow, m_un);
  endtask

  task automatic model_reset();
    q.delete();
    wcnt = 0; rcnt = 0; m_ov = 0; m_un = 0;
  endtask

  // One cycle: drive after negedge, check combinational view, advance model at posedge.
  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    int n = q.size();
    bit wok, pok;
    logic [7:0] tmp;
    wr_req = w; rd_req = r; clr_err = c; w_data = d;
    #1;
    wok = w && (n < DEPTH);
    pok = r && (n > 0);
    chk("ram_we", ram_we, wok);
    chk("w_addr", ram_w_addr, wcnt % DEPTH);
    chk("r_addr", ram_r_addr, rcnt % DEPTH);
    if (n > 0) chk("r_data", r_data, q[0]);
    check_flags();
    @(posedge clk);
    if (pok) begin tmp = q.pop_front(); rcnt++; end
    if (wok) begin q.push_back(d); wcnt++; end
    if (w && n == DEPTH) m_ov = 1; else if (c) m_ov = 0;
    if (r && n == 0)     m_un = 1; else if (c) m_un = 0;
    @(negedge clk);
    wr_req = 0; rd_req = 0; clr_err = 0;
  endtask

  initial begin
    int w0;
    // Reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    reset = 1'b0;
    model_reset();
    #1;
    check_flags();
    chk("rst_we", ram_we, 0);
    chk("rst_waddr", ram_w_addr, 0);
    chk("rst_raddr", ram_r_addr, 0);

    // Fill with A0..A7, then one overflowing push
    for (int i = 0; i < 8; i++) step(1, 0, 0, 8'hA0 + 8'(i));
    step(1, 0, 0, 8'hEE);
    check_flags();

    // Drain in order, one underflowing pop, then clear errors
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    check_flags();

    // Wrap: push 5, pop 5, push 6
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h10 + i));
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 8'(8'h20 + i));
    check_flags();

    // Hold at count 4 with simultaneous requests for 10 cycles
    step(0, 1, 0, 8'h00); step(0, 1, 0, 8'h00);
    w0 = wcnt;
    for (int i = 0; i < 10; i++) step(1, 1, 0, 8'(8'h30 + i));
    chk("sim_count", count, 4);
    chk("sim_wadv", wcnt - w0, 10);
    chk("sim_waddr", ram_w_addr, wcnt % DEPTH);

    // Simultaneous requests at full and at empty, plus set-vs-clear priority
    while (q.size() < DEPTH) step(1, 0, 0, 8'($urandom));
    step(1, 1, 1, 8'h55);
    while (q.size() > 0) step(0, 1, 0, 8'h00);
    step(1, 1, 1, 8'h66);
    step(0, 1, 0, 8'h00);
    check_flags();

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 5, 8'($urandom));

    // Async reset mid-burst at count 5 with an error pending
    while (q.size() > 0) step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h40 + i));
    reset = 1'b1;
    #1;
    model_reset();
    check_flags();
    chk("mid_raddr", ram_r_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 8'h77);
    step(0, 0, 0, 8'h00);
    chk("post_rst_data", r_data, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
